// File: rtl/dma_requester_if.sv
// Handshake bundle for the four-channel DMA requester.
// The err vector only exists when DMA_REQ_TIMEOUT_EN is defined.
interface dma_requester_if #(
  parameter int CNT_W = 8
);
  logic [3:0]         start;
  logic [CNT_W-1:0]   len;
  logic [3:0]         abort;
  logic [3:0]         DACK;
  logic [3:0]         DREQ;
  logic [3:0]         TC;
  logic [3:0]         busy;
  logic [4*CNT_W-1:0] rem;
`ifdef DMA_REQ_TIMEOUT_EN
  logic [3:0]         err;
`endif

  // The requester itself: takes commands and acks, drives requests and status.
  modport master (
    input  start, len, abort, DACK,
    output DREQ, TC, busy, rem
`ifdef DMA_REQ_TIMEOUT_EN
    , output err
`endif
  );

  // The surrounding controller/arbiter side.
  modport slave (
    output start, len, abort, DACK,
    input  DREQ, TC, busy, rem
`ifdef DMA_REQ_TIMEOUT_EN
    , input err
`endif
  );
endinterface

// File: rtl/dma_requester.sv
// Four independent DMA request channels: each counts granted beats and pulses TC at the end.
// Optional DREQ-without-DACK timeout with an ERR state is enabled by defining DMA_REQ_TIMEOUT_EN.
module dma_requester #(
  parameter int CNT_W   = 8,
  parameter int TMO_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  dma_requester_if.master bus
);

`ifdef DMA_REQ_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
  localparam int TMO_W = $clog2(TMO_CYC + 1);
`else
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_ch
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] rem_q;
    logic             load;
    logic             dreq;
    logic             tc;
    logic             busy;
`ifdef DMA_REQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             err;

    // Hit on the cycle that would make the stall count reach TMO_CYC.
    assign tmo_hit = !bus.DACK[i] && (tmo_cnt == TMO_W'(TMO_CYC - 1));
`endif

    assign load = bus.start[i] && (bus.len != '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
      end else begin
        state <= next_state;
      end
    end

    always_comb begin
      next_state = state;
      case (state)
        IDLE: if (load) next_state = REQ;
        REQ: begin
          if (bus.abort[i]) begin
            next_state = IDLE;
          end else if (bus.DACK[i] && (rem_q == CNT_W'(1))) begin
            next_state = DONE;
`ifdef DMA_REQ_TIMEOUT_EN
          end else if (tmo_hit) begin
            next_state = ERR;
`endif
          end
        end
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end

    always_comb begin
      dreq = 1'b0;
      tc   = 1'b0;
      busy = (state != IDLE);
`ifdef DMA_REQ_TIMEOUT_EN
      err  = (state == ERR);
`endif
      case (state)
        REQ:     dreq = 1'b1;
        DONE:    tc   = 1'b1;
        default: ;
      endcase
    end

    // Abort wins over a same-cycle ack; acks outside REQ never touch the counter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rem_q <= '0;
      end else begin
        case (state)
          IDLE: if (load) rem_q <= bus.len;
          REQ: begin
            if (bus.abort[i]) begin
              rem_q <= '0;
            end else if (bus.DACK[i] && (rem_q != '0)) begin
              rem_q <= rem_q - CNT_W'(1);
`ifdef DMA_REQ_TIMEOUT_EN
            end else if (tmo_hit) begin
              rem_q <= '0;
`endif
            end
          end
          default: ;
        endcase
      end
    end

`ifdef DMA_REQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tmo_cnt <= '0;
      end else if ((state == REQ) && !bus.DACK[i] && (next_state == REQ)) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end
    end

    assign bus.err[i] = err;
`endif

    assign bus.DREQ[i]                = dreq;
    assign bus.TC[i]                  = tc;
    assign bus.busy[i]                = busy;
    assign bus.rem[i*CNT_W +: CNT_W]  = rem_q;
  end

endmodule

// File: doc/dma_requester.md
DMA_REQUESTER -- requirements
Module: dma_requester

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of the per-channel transfer length and remaining-beat counter.
REQ-002 Parameter TMO_CYC, default 255, SHALL set the DREQ-without-DACK timeout in cycles (used only when DMA_REQ_TIMEOUT_EN is defined).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  input  4  SHALL carry per-channel one-cycle pulses requesting a block transfer.
REQ-006 len  input  CNT_W  SHALL give the beat count, sampled by every channel whose start bit is high.
REQ-007 abort  input  4  SHALL carry per-channel cancel requests.
REQ-008 DACK  input  4  SHALL carry one-hot acknowledges from the channel arbiter; each high cycle grants one beat.
REQ-009 DREQ  output  4  SHALL carry per-channel registered DMA requests toward the arbiter.
REQ-010 TC  output  4  SHALL carry one-cycle terminal-count pulses per channel.
REQ-011 busy  output  4  SHALL be high per channel while its FSM is not in IDLE.
REQ-012 rem  output  4*CNT_W  SHALL expose the remaining-beat counters, channel 0 in the LSBs.

Function
REQ-013 Each channel SHALL run an independent FSM with states IDLE, REQ and DONE, plus ERR when DMA_REQ_TIMEOUT_EN is defined.
REQ-014 IDLE -> REQ SHALL occur on start[i]=1 with len!=0; rem[i] loads len and DREQ[i] rises on the following edge (1-cycle latency).
REQ-015 start[i] with len=0 SHALL be ignored: no DREQ and no TC.
REQ-016 start[i] while busy[i]=1 SHALL be ignored; rem[i] is not reloaded.
REQ-017 DREQ[i] SHALL equal 1 exactly when channel i is in REQ.
REQ-018 In REQ, each cycle with DACK[i]=1 SHALL decrement rem[i] by 1; consecutive DACK cycles give back-to-back beats.
REQ-019 In REQ, DACK[i]=1 with rem[i]=1 SHALL move the channel to DONE; DREQ[i] falls on that edge.
REQ-020 In DONE, TC[i] SHALL be 1 for exactly one cycle, and the channel SHALL return to IDLE on the next edge.
REQ-021 DACK[i] SHALL be ignored in IDLE and DONE; rem[i] never decrements below 0 (no wrap).
REQ-022 DACK with multiple bits set SHALL be applied per bit independently; there is no cross-channel check.
REQ-023 abort[i]=1 in REQ SHALL force IDLE on the next edge without a TC pulse and clear rem[i]; abort has priority over a same-cycle DACK[i].
REQ-024 abort[i] in IDLE or DONE SHALL have no effect.
REQ-025 TC SHALL be a registered output decoded from the DONE state.

Reset
REQ-026 rst_n=0 SHALL immediately force every channel to IDLE, with DREQ=0, TC=0, busy=0, rem=0 and timeout counters=0, regardless of clk.
REQ-027 Reset asserted mid-transfer SHALL discard the transfer; after release the channel stays in IDLE until a new start.

Configuration
REQ-028 With macro DMA_REQ_TIMEOUT_EN defined:
- Each channel SHALL count consecutive REQ cycles with DACK[i]=0, clearing the count on any DACK[i]=1.
- When the count reaches TMO_CYC, the channel SHALL enter ERR for one cycle, with DREQ=0 and rem cleared, then return to IDLE.
- Output err (4 bits) SHALL pulse for one cycle per channel on entry to ERR; no TC is issued.
REQ-029 With DMA_REQ_TIMEOUT_EN undefined:
- There SHALL be no err port, no timeout counter and no ERR state.
- DREQ SHALL be held indefinitely until DACK or abort.

Verification
REQ-030 start=0001, len=3; DACK[0] high for 3 consecutive cycles after DREQ[0] rises -> rem steps 3,2,1,0; DREQ[0] falls after the 3rd ack; TC[0] pulses once, one cycle later.
REQ-031 start=1111, len=1; DACK driven one-hot round-robin 0001, 0010, 0100, 1000 -> each channel gets one TC pulse, in order, each one cycle after its ack.
REQ-032 start=0100, len=5; abort[2] asserted in the same cycle as the 2nd DACK[2] -> rem[2]=0, channel back in IDLE, no TC pulse.
REQ-033 start=0010 with len=0 -> DREQ stays 0; then start=0010, len=2, and a second start with len=7 during REQ -> completes after exactly 2 acks.
REQ-034 rst_n driven low mid-transfer (rem=4) -> outputs clear asynchronously; after release there is no DREQ until a new start.
REQ-035 DMA_REQ_TIMEOUT_EN defined, TMO_CYC=8, no DACK -> DREQ drops and err pulses 8 cycles after DREQ rises; with the macro undefined, DREQ stays high for at least 300 cycles.
